// File: rtl/vr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vr_sequencer
// Purpose  : Instruction-phase controller for the 8-bit accumulator CPU.
//            Steps a 3-bit phase counter through eight phases per
//            instruction and decodes phase, opcode and the zero flag into
//            the datapath load/enable/select strobes.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   c       in   1  clock, rising edge
//   r       in   1  reset, asynchronous, active-high
//   e       in   1  phase advance enable (phase holds when 0)
//   opcode  in   3  instruction register opcode field
//   zero    in   1  accumulator-is-zero flag
//   phase   out  3  current phase 0..7
//   sel     out  1  address mux select (1 = PC, 0 = IR operand)
//   rd      out  1  memory read strobe
//   ld_ir   out  1  instruction register load
//   inc_pc  out  1  program counter increment
//   ld_pc   out  1  program counter load
//   data_e  out  1  accumulator-to-bus driver enable
//   ld_ac   out  1  accumulator load
//   wr      out  1  memory write strobe
//   halt    out  1  processor halted
// ============================================================================
module vr_sequencer (
  input  logic       c,
  input  logic       r,
  input  logic       e,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic [2:0] phase,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       data_e,
  output logic       ld_ac,
  output logic       wr,
  output logic       halt
);

  localparam logic [2:0] PH_INST_ADDR  = 3'd0;
  localparam logic [2:0] PH_INST_FETCH = 3'd1;
  localparam logic [2:0] PH_INST_LOAD  = 3'd2;
  localparam logic [2:0] PH_IDLE       = 3'd3;
  localparam logic [2:0] PH_OP_ADDR    = 3'd4;
  localparam logic [2:0] PH_OP_FETCH   = 3'd5;
  localparam logic [2:0] PH_ALU_OP     = 3'd6;
  localparam logic [2:0] PH_STORE      = 3'd7;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  logic       halted;
  logic [2:0] phase_nxt;
  logic       halted_nxt;
  logic       aluop;
  logic       hlt_now;

  // ADD, AND, XOR and LDA occupy the contiguous opcode range 2..5
  assign aluop   = (opcode >= OP_ADD) && (opcode <= OP_LDA);
  assign hlt_now = (phase == PH_OP_ADDR) && (opcode == OP_HLT);

  // State register
  always_ff @(posedge c or posedge r) begin
    if (r) begin
      phase  <= PH_INST_ADDR;
      halted <= 1'b0;
    end else begin
      phase  <= phase_nxt;
      halted <= halted_nxt;
    end
  end

  // Next-state logic. A HLT in OP_ADDR latches halted instead of advancing,
  // so the phase stays frozen at 4 for the whole halted period.
  always_comb begin
    phase_nxt  = phase;
    halted_nxt = halted;
    if (e && !halted) begin
      if (hlt_now) begin
        halted_nxt = 1'b1;
      end else begin
        phase_nxt = phase + 3'd1;
      end
    end
  end

  // Output decode: pure function of registered phase/halted plus opcode/zero
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    data_e = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    halt   = 1'b0;
    if (halted) begin
      halt = 1'b1;
    end else begin
      case (phase)
        PH_INST_ADDR: begin
          sel = 1'b1;
        end
        PH_INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        PH_INST_LOAD, PH_IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        PH_OP_ADDR: begin
          inc_pc = (opcode != OP_HLT);
          halt   = (opcode == OP_HLT);
        end
        PH_OP_FETCH: begin
          rd = aluop;
        end
        PH_ALU_OP: begin
          // data_e leads wr by one phase so bus data settles before the write
          rd     = aluop;
          inc_pc = (opcode == OP_SKZ) && zero;
          ld_pc  = (opcode == OP_JMP);
          data_e = (opcode == OP_STO);
        end
        PH_STORE: begin
          rd     = aluop;
          ld_ac  = aluop;
          ld_pc  = (opcode == OP_JMP);
          data_e = (opcode == OP_STO);
          wr     = (opcode == OP_STO);
        end
        default: begin
          sel = 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vr_sequencer
// Purpose  : Self-checking bench for vr_sequencer. A phase/halted model
//            computes expected strobes from the instruction-phase rules;
//            directed scans pin literal per-phase strobe patterns, then a
//            randomized run is checked against the model every cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_vr_sequencer;

  logic       c;
  logic       r;
  logic       e;
  logic [2:0] opcode;
  logic       zero;
  logic [2:0] phase;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, data_e, ld_ac, wr, halt;
  logic [8:0] strb;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 0;

  int m_phase  = 0;
  bit m_halted = 0;

  vr_sequencer dut (
    .c      (c),
    .r      (r),
    .e      (e),
    .opcode (opcode),
    .zero   (zero),
    .phase  (phase),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .data_e (data_e),
    .ld_ac  (ld_ac),
    .wr     (wr),
    .halt   (halt)
  );

  assign strb = {sel, rd, ld_ir, inc_pc, ld_pc, data_e, ld_ac, wr, halt};

  initial begin
    c = 1'b0;
    forever #5 c = ~c;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, got, exp);
  endtask

  // Expected strobes {sel,rd,ld_ir,inc_pc,ld_pc,data_e,ld_ac,wr,halt}
  function automatic logic [8:0] model_strb(input int ph, input bit hl,
                                            input logic [2:0] op, input logic z);
    bit alu, s, rdx, ir, inc, lpc, de, lac, w, h;
    alu = (op >= 3'd2) && (op <= 3'd5);
    if (hl) return 9'b0_0000_0001;
    s   = (ph <= 3);
    rdx = ((ph >= 1) && (ph <= 3)) || ((ph >= 5) && alu);
    ir  = (ph == 2) || (ph == 3);
    inc = ((ph == 4) && (op != 3'd0)) || ((ph == 6) && (op == 3'd1) && (z == 1'b1));
    lpc = (ph >= 6) && (op == 3'd7);
    de  = (ph >= 6) && (op == 3'd6);
    lac = (ph == 7) && alu;
    w   = (ph == 7) && (op == 3'd6);
    h   = (ph == 4) && (op == 3'd0);
    return {s, rdx, ir, inc, lpc, de, lac, w, h};
  endfunction

  // Model state: advance per enabled edge, halt latch, async clear
  always @(posedge c or posedge r) begin
    if (r) begin
      m_phase  <= 0;
      m_halted <= 1'b0;
    end else if (e && !m_halted) begin
      if (m_phase == 4 && opcode == 3'd0) m_halted <= 1'b1;
      else m_phase <= (m_phase + 1) % 8;
    end
  end

  // Per-cycle compare, away from the active edge
  always @(negedge c) begin
    if (chk_en && !r) begin
      chk("model_phase", 32'(phase), 32'(m_phase));
      chk("model_strb", 32'(strb), 32'(model_strb(m_phase, m_halted, opcode, zero)));
      chk("exclusion", 32'({ld_pc & inc_pc, wr & rd, wr & ~data_e}), 32'd0);
    end
  end

  task automatic tick();
    @(posedge c);
    #2;
  endtask

  task automatic rst_pulse();
    r = 1'b1;
    #1;
    chk("async_rst_phase", 32'(phase), 32'd0);
    r = 1'b0;
  endtask

  // Run one instruction from reset, capturing per-phase strobe masks
  task automatic scan(input logic [2:0] op, input logic z,
                      output logic [7:0] rdm, output logic [7:0] incm,
                      output logic [7:0] lpcm, output logic [7:0] dem,
                      output logic [7:0] wrm, output logic [7:0] lacm);
    rst_pulse();
    opcode = op;
    zero   = z;
    e      = 1'b1;
    for (int p = 0; p < 8; p++) begin
      @(negedge c);
      #1;
      chk("scan_phase", 32'(phase), 32'(p));
      rdm[p]  = rd;
      incm[p] = inc_pc;
      lpcm[p] = ld_pc;
      dem[p]  = data_e;
      wrm[p]  = wr;
      lacm[p] = ld_ac;
      if (op == 3'd1 && p == 5) begin
        zero = ~zero;
        #1;
        chk("skz_zero_in_ph5", 32'(strb), 32'd0);
        zero = ~zero;
      end
      tick();
    end
    chk("scan_wrap", 32'(phase), 32'd0);
  endtask

  logic [7:0] rdm, incm, lpcm, dem, wrm, lacm;
  int hc;

  initial begin
    r = 1'b1; e = 1'b0; opcode = 3'd0; zero = 1'b0;
    repeat (2) @(posedge c);
    #2;
    chk("reset_phase", 32'(phase), 32'd0);
    chk("reset_strb", 32'(strb), 32'h100);
    r = 1'b0;
    #1;
    chk("post_reset_strb", 32'(strb), 32'h100);
    chk_en = 1;
    tick();

    // ADD
    scan(3'd2, 1'b0, rdm, incm, lpcm, dem, wrm, lacm);
    chk("add_rd", 32'(rdm), 32'hEE);
    chk("add_ld_ac", 32'(lacm), 32'h80);
    chk("add_inc_pc", 32'(incm), 32'h10);
    // SKZ, zero taken / not taken
    scan(3'd1, 1'b1, rdm, incm, lpcm, dem, wrm, lacm);
    chk("skz1_inc_pc", 32'(incm), 32'h50);
    scan(3'd1, 1'b0, rdm, incm, lpcm, dem, wrm, lacm);
    chk("skz0_inc_pc", 32'(incm), 32'h10);
    // STO
    scan(3'd6, 1'b0, rdm, incm, lpcm, dem, wrm, lacm);
    chk("sto_data_e", 32'(dem), 32'hC0);
    chk("sto_wr", 32'(wrm), 32'h80);
    chk("sto_rd", 32'(rdm), 32'h0E);
    // JMP
    scan(3'd7, 1'b1, rdm, incm, lpcm, dem, wrm, lacm);
    chk("jmp_ld_pc", 32'(lpcm), 32'hC0);
    chk("jmp_inc_pc", 32'(incm), 32'h10);

    // HLT
    rst_pulse();
    opcode = 3'd0;
    e = 1'b1;
    repeat (4) tick();
    @(negedge c);
    chk("hlt_ph4_phase", 32'(phase), 32'd4);
    chk("hlt_ph4_halt", 32'(halt), 32'd1);
    chk("hlt_ph4_inc_pc", 32'(inc_pc), 32'd0);
    tick();
    for (int i = 0; i < 20; i++) begin
      @(negedge c);
      chk("halted_phase", 32'(phase), 32'd4);
      chk("halted_strb", 32'(strb), 32'h001);
      tick();
    end
    rst_pulse();
    chk("unhalt_strb", 32'(strb), 32'h100);

    // Stall at phase 2, then async reset at phase 5
    opcode = 3'd2;
    e = 1'b1;
    tick();
    tick();
    e = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge c);
      chk("stall_phase", 32'(phase), 32'd2);
      chk("stall_ld_ir", 32'(ld_ir), 32'd1);
      tick();
    end
    e = 1'b1;
    repeat (3) tick();
    chk("pre_rst_phase", 32'(phase), 32'd5);
    #1;
    r = 1'b1;
    #1;
    chk("midcycle_rst_phase", 32'(phase), 32'd0);
    chk("midcycle_rst_strb", 32'(strb), 32'h100);
    r = 1'b0;

    // Randomized run
    hc = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) opcode = 3'($urandom_range(0, 7));
      e    = ($urandom_range(0, 7) != 0);
      zero = 1'($urandom_range(0, 1));
      tick();
      if (m_halted) hc++;
      else hc = 0;
      if (hc > 3 || $urandom_range(0, 255) == 0) begin
        #1;
        rst_pulse();
        hc = 0;
      end
    end

    @(negedge c);
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
